// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage valid/ready Vedic multiplier for the RV32M execute stage.
// Handles MUL / MULH / MULHSU / MULHU through sign-magnitude conversion, four
// half-width Vedic partial products and a carry-lookahead combine. A destination
// tag rides alongside each operation.
module vedic_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int H      = WIDTH / 2;
  localparam int PW     = 2 * WIDTH;
  localparam int LEAVES = H / 4;

  // 4x4 Urdhva-Tiryagbhyam leaf: each output column k sums the vertical and
  // crosswise bit products x[i]&y[j] with i+j==k.
  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] acc;
    logic [2:0] col;
    acc = '0;
    for (int k = 0; k < 7; k++) begin
      col = '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (i + j == k) col = col + {2'b00, x[i] & y[j]};
        end
      end
      acc = acc + ({5'b00000, col} << k);
    end
    return acc;
  endfunction

  // Half-width Vedic multiplier. The recursive hi/lo split bottoms out in 4x4
  // leaves; the whole tree is flattened into a sum of shifted leaf products.
  function automatic logic [2*H-1:0] vedic_half(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [2*H-1:0] acc;
    logic [2*H-1:0] term;
    acc = '0;
    for (int i = 0; i < LEAVES; i++) begin
      for (int j = 0; j < LEAVES; j++) begin
        term      = '0;
        term[7:0] = vedic4(x[4*i +: 4], y[4*j +: 4]);
        acc       = acc + (term << (4 * (i + j)));
      end
    end
    return acc;
  endfunction

  // Generate/propagate adder over the full product width; the carry recurrence
  // is written flat so synthesis can build the lookahead tree.
  function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] c;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int i = 1; i < PW; i++) c[i] = g[i-1] | (p[i-1] & c[i-1]);
    return p ^ c;
  endfunction

  logic stall;
  logic vld_p0, vld_p1;

  logic [WIDTH-1:0] mag_a_p0, mag_b_p0;
  logic             neg_p0;
  logic [1:0]       mode_p0;
  logic [TAG_W-1:0] tag_p0;

  logic [2*H-1:0]   ll_p1, hl_p1, lh_p1, hh_p1;
  logic             neg_p1;
  logic [1:0]       mode_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    ll_x, hl_x, lh_x, hh_x, mid, prod, res;
  logic [WIDTH-1:0] res_sel;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign busy     = vld_p0 | vld_p1 | out_valid;

  // Stage 0 input: operand signedness from mode and conversion to magnitudes.
  // MUL low half is signedness-agnostic, so it shares the signed x signed path.
  always_comb begin
    a_signed = (in_mode != 2'b11);
    b_signed = (in_mode == 2'b00) || (in_mode == 2'b01);
    neg_a    = a_signed & in_a[WIDTH-1];
    neg_b    = b_signed & in_b[WIDTH-1];
    mag_a    = neg_a ? (~in_a + WIDTH'(1)) : in_a;
    mag_b    = neg_b ? (~in_b + WIDTH'(1)) : in_b;
  end

  // Stage 2 combine: hh<<WIDTH + (hl+lh)<<H + ll, keeping the middle-sum carry,
  // then restore the sign and select the requested half.
  always_comb begin
    ll_x = '0;
    hl_x = '0;
    lh_x = '0;
    hh_x = '0;
    ll_x[2*H-1:0] = ll_p1;
    hl_x[2*H-1:0] = hl_p1;
    lh_x[2*H-1:0] = lh_p1;
    hh_x[2*H-1:0] = hh_p1;
    mid     = cla_add(hl_x, lh_x);
    prod    = cla_add(cla_add(hh_x << WIDTH, mid << H), ll_x);
    res     = neg_p1 ? cla_add(~prod, PW'(1)) : prod;
    res_sel = (mode_p1 == 2'b00) ? res[WIDTH-1:0] : res[PW-1:WIDTH];
  end

  // Valid bits and the registered result: flush beats stall, stall freezes all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_result <= res_sel;
        out_tag    <= tag_p1;
      end
    end
  end

  // Datapath registers for stages 0 and 1; they only move when the pipe advances.
  always_ff @(posedge clk) begin
    if (!stall) begin
      // stage 0: magnitudes, sign, mode, tag
      if (in_valid) begin
        mag_a_p0 <= mag_a;
        mag_b_p0 <= mag_b;
        neg_p0   <= neg_a ^ neg_b;
        mode_p0  <= in_mode;
        tag_p0   <= in_tag;
      end
      // stage 1: four half-width partial products
      if (vld_p0) begin
        ll_p1   <= vedic_half(mag_a_p0[H-1:0],     mag_b_p0[H-1:0]);
        hl_p1   <= vedic_half(mag_a_p0[WIDTH-1:H], mag_b_p0[H-1:0]);
        lh_p1   <= vedic_half(mag_a_p0[H-1:0],     mag_b_p0[WIDTH-1:H]);
        hh_p1   <= vedic_half(mag_a_p0[WIDTH-1:H], mag_b_p0[WIDTH-1:H]);
        neg_p1  <= neg_p0;
        mode_p1 <= mode_p0;
        tag_p1  <= tag_p0;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Testbench for vedic_mult_pipe: a 32-bit and an 8-bit instance, each with an
// expected-result queue filled at accept time and drained at the output handshake.
module tb_vedic_mult_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_result;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;

  // 8-bit instance
  logic        rst8_n, flush8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_a8, in_b8, out_result8;
  logic [1:0]  in_mode8;
  logic [4:0]  in_tag8, out_tag8;

  exp_t q32[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd32 = 1'b0;
  bit   rnd8  = 1'b0;
  bit   done8 = 1'b0;

  vedic_mult_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  vedic_mult_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(rst8_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_mode(in_mode8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
    .out_tag(out_tag8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits and multiply; the low 64 bits of
  // the two's-complement product are exact for w <= 32.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m, input int w);
    logic [63:0] mask, ax, bx, p;
    mask = (64'd1 << w) - 64'd1;
    ax = {32'd0, a} & mask;
    bx = {32'd0, b} & mask;
    if (m != 2'b11 && ax[w-1]) ax = ax | ~mask;
    if ((m == 2'b00 || m == 2'b01) && bx[w-1]) bx = bx | ~mask;
    p = ax * bx;
    if (m == 2'b00) return 32'(p & mask);
    return 32'((p >> w) & mask);
  endfunction

  // Present one beat on the 32-bit unit and wait until it is accepted.
  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic [4:0] t, input logic [31:0] e);
    bit acc;
    int g;
    acc = 1'b0;
    g   = 0;
    in_a = a; in_b = b; in_mode = m; in_tag = t; in_valid = 1'b1;
    while (!acc && g < 400) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      g++;
    end
    if (acc) q32.push_back('{res: e, tag: t});
    else chk("accept32_timeout", 64'(0), 64'(1));
  endtask

  // Count edges from the accept edge until out_valid shows; expect 3.
  task automatic lat_check(input string tag);
    int n;
    n = 1;
    while (n < 12) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(n), 64'(3));
    @(posedge clk);
    #1;
  endtask

  task automatic drain32(input string tag);
    int g;
    g = 0;
    while (q32.size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk(tag, 64'(q32.size()), 64'(0));
  endtask

  // Output monitor for the 32-bit unit: scoreboard pop, hold-while-stalled, in_ready.
  initial begin : mon32
    exp_t        e;
    logic        hv;
    logic [31:0] hr;
    logic [4:0]  ht;
    hv = 1'b0; hr = '0; ht = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 1'b0;
      end else begin
        if (hv) begin
          chk("hold_vld", 64'(out_valid), 64'(1));
          chk("hold_res", 64'(out_result), 64'(hr));
          chk("hold_tag", 64'(out_tag), 64'(ht));
        end
        hv = out_valid && !out_ready && !flush;
        hr = out_result;
        ht = out_tag;
        chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && out_ready && !flush) begin
          if (q32.size() == 0) chk("unexpected32", 64'(1), 64'(0));
          else begin
            e = q32.pop_front();
            chk("res32", 64'(out_result), 64'(e.res));
            chk("tag32", 64'(out_tag), 64'(e.tag));
          end
        end
      end
    end
  end

  // Output monitor for the 8-bit unit.
  initial begin : mon8
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst8_n && out_valid8 && out_ready8) begin
        if (q8.size() == 0) chk("unexpected8", 64'(1), 64'(0));
        else begin
          e = q8.pop_front();
          chk("res8", 64'(out_result8), 64'(e.res[7:0]));
          chk("tag8", 64'(out_tag8), 64'(e.tag));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd32) out_ready = ($urandom_range(3) != 0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd8) out_ready8 = ($urandom_range(3) != 0);
  end

  // Random stream through the 8-bit unit, running alongside the 32-bit tests.
  initial begin : drv8
    logic [7:0] c8[4];
    logic [7:0] a, b;
    logic [1:0] m;
    logic [4:0] t;
    bit         acc;
    int         g;
    c8 = '{8'h00, 8'h80, 8'h7f, 8'hff};
    rst8_n = 1'b0; flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    in_a8 = '0; in_b8 = '0; in_mode8 = '0; in_tag8 = '0;
    repeat (2) @(posedge clk);
    #2 rst8_n = 1'b1;
    @(posedge clk);
    #1;
    rnd8 = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (i < 64) begin
        a = c8[i % 4]; b = c8[(i / 4) % 4]; m = 2'(i / 16);
      end else begin
        a = 8'($urandom); b = 8'($urandom); m = 2'($urandom);
      end
      t = 5'($urandom);
      in_a8 = a; in_b8 = b; in_mode8 = m; in_tag8 = t; in_valid8 = 1'b1;
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 400) begin
        @(negedge clk);
        acc = in_ready8;
        @(posedge clk);
        #1;
        g++;
      end
      if (acc) q8.push_back('{res: ref_mul({24'd0, a}, {24'd0, b}, m, 8), tag: t});
      else chk("accept8_timeout", 64'(0), 64'(1));
      if ($urandom_range(7) == 0) begin
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid8 = 1'b0;
    rnd8 = 1'b0;
    out_ready8 = 1'b1;
    g = 0;
    while (q8.size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("drain8", 64'(q8.size()), 64'(0));
    chk("busy8_idle", 64'(busy8), 64'(0));
    done8 = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] c32[4];
    logic [31:0] a, b;
    logic [1:0]  m;
    logic [4:0]  t;
    int          g;
    c32 = '{32'h0000_0000, 32'h8000_0000, 32'h7fff_ffff, 32'hffff_ffff};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
    #20;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // MUL with a negative operand, then latency
    drive32(32'h0000_0007, 32'hffff_fffd, 2'b00, 5'd3, 32'hffff_ffeb);
    in_valid = 1'b0;
    lat_check("lat_mul");

    // high-half modes at the sign boundary
    drive32(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd4, 32'h4000_0000);
    drive32(32'h8000_0000, 32'h8000_0000, 2'b11, 5'd5, 32'h4000_0000);
    drive32(32'hffff_ffff, 32'hffff_ffff, 2'b10, 5'd6, 32'hffff_ffff);
    drive32(32'h8000_0000, 32'hffff_ffff, 2'b00, 5'd7, 32'h8000_0000);
    in_valid = 1'b0;
    drain32("drain_modes");

    // 8 back-to-back beats, consumer stalls 4 cycles at beat 3
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        fork
          begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
          end
        join_none
      end
      a = 32'h1234_5679 * (i + 1);
      b = 32'h9e37_79b9 ^ (i * 32'h0101_0101);
      m = 2'(i);
      drive32(a, b, m, 5'(i + 8), ref_mul(a, b, m, 32));
    end
    in_valid = 1'b0;
    drain32("drain_stall");

    // flush with 3 beats in flight and a 4th presented
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive32(32'd100 + i, 32'd7, 2'b00, 5'(i + 16), 32'd700 + 7 * i);
    in_a = 32'd55; in_b = 32'd2; in_mode = 2'b00; in_tag = 5'd19; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("flush_quiet", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    drive32(32'hffff_fff0, 32'h0000_0010, 2'b11, 5'd20, 32'h0000_000f);
    in_valid = 1'b0;
    lat_check("lat_flush");

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) drive32(32'h101 + i, 32'd3, 2'b00, 5'(i + 21), 32'h303 + 3 * i);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_result", 64'(out_result), 64'(0));
    chk("arst_out_tag", 64'(out_tag), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    q32.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    drive32(32'hfffe_0001, 32'h0003_0000, 2'b01, 5'd30, 32'hffff_fffa);
    in_valid = 1'b0;
    lat_check("lat_rst");

    // random operands, all modes, random consumer back-pressure
    rnd32 = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (i < 64) begin
        a = c32[i % 4]; b = c32[(i / 4) % 4]; m = 2'(i / 16);
      end else begin
        a = $urandom; b = $urandom; m = 2'($urandom);
      end
      t = 5'($urandom);
      drive32(a, b, m, t, ref_mul(a, b, m, 32));
      if ($urandom_range(7) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rnd32 = 1'b0;
    out_ready = 1'b1;
    drain32("drain_rand32");
    chk("busy_idle", 64'(busy), 64'(0));

    g = 0;
    while (!done8 && g < 60000) begin
      @(posedge clk);
      g++;
    end
    chk("done8", 64'(done8), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
